// File: rtl/timer_arb_pkg.sv
// Shared types and constants for the timer_arbiter slice.
package timer_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int CNT_W_DEFAULT = 4;
  localparam int N_REQ_MIN     = 2;
  localparam int N_REQ_MAX     = 8;

endpackage

// File: rtl/count_down_ld.sv
// Loadable down-counter with clear and zero flag; stops at 0 instead of wrapping.
module count_down_ld #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  assign zero  = (count_q == '0);
  assign count = count_q;

  // clr beats load beats decrement.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en && !zero) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one loadable down-counter among N_REQ requesters.
// Define TIMER_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] delay,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [CNT_W-1:0]       count,
  output logic [1:0]             state_dbg_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Handshake: req[i] is a level held until done[i] pulses or the requester
  // drops it; dropping it while granted aborts the timer with no done pulse.
  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               busy_q, busy_d;
  logic [IDX_W-1:0]   win_idx, cand;
  logic [N_REQ-1:0]   win_oh;
  logic               win_found;
  logic               cnt_load, cnt_en, cnt_clr, cnt_zero;
  logic [CNT_W-1:0]   delay_arr [N_REQ];
`ifndef TIMER_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]   last_q, last_d;
`endif

  for (genvar g = 0; g < N_REQ; g++) begin : g_delay
    assign delay_arr[g] = delay[g*CNT_W +: CNT_W];
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
`ifdef TIMER_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`else
    // Search starts just past the previous winner so it ends up last.
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last_q) + k) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`endif
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b0;
`ifndef TIMER_ARB_FIXED_PRIO_EN
    last_d   = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d  = ST_COUNT;
          grant_d  = win_oh;
          cnt_load = 1'b1;
`ifndef TIMER_ARB_FIXED_PRIO_EN
          last_d   = win_idx;
`endif
        end
      end
      ST_COUNT: begin
        // Abort wins over reaching zero.
        if ((req & grant_q) == '0) begin
          state_d = ST_IDLE;
          grant_d = '0;
          cnt_clr = 1'b1;
        end else if (cnt_zero) begin
          state_d = ST_DONE;
          done_d  = grant_q;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_clr = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
`ifndef TIMER_ARB_FIXED_PRIO_EN
      last_q  <= IDX_W'(N_REQ - 1);
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifndef TIMER_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  count_down_ld #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (delay_arr[win_idx]),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .count    (count),
    .zero     (cnt_zero)
  );

  assign grant       = grant_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Table-driven bench for timer_arbiter with an expected-output queue.
module tb_timer_arbiter;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int EW = 2*N + 1 + W;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] delay;
  logic [N-1:0]   grant, done;
  logic           busy;
  logic [W-1:0]   count;
  logic [1:0]     state_dbg;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] delay;
    logic [N-1:0]   g;
    logic [N-1:0]   d;
    logic           b;
    logic [W-1:0]   c;
    string          name;
  } vec_t;

  vec_t           vecs[$];
  logic [EW-1:0]  exp_q[$];

  timer_arbiter #(.N_REQ(N), .CNT_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .delay       (delay),
    .grant       (grant),
    .done        (done),
    .busy        (busy),
    .count       (count),
    .state_dbg_o (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] dly(input int idx, input int val);
    logic [N*W-1:0] r;
    r = '0;
    r[idx*W +: W] = W'(val);
    return r;
  endfunction

  task automatic add(input logic [N-1:0] rq, input logic [N*W-1:0] dl,
                     input logic [N-1:0] g, input logic [N-1:0] d,
                     input logic b, input logic [W-1:0] c, input string name);
    vec_t v;
    v.req = rq; v.delay = dl; v.g = g; v.d = d; v.b = b; v.c = c; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic expect_out(input logic [N-1:0] g, input logic [N-1:0] d,
                            input logic b, input logic [W-1:0] c);
    exp_q.push_back({g, d, b, c});
  endtask

  // scoreboard
  task automatic check_out(input string name);
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    a = {grant, done, busy, count};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: no expected entry queued, got %b", name, a);
      return;
    end
    e = exp_q.pop_front();
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got grant=%b done=%b busy=%b count=%0d, want grant=%b done=%b busy=%b count=%0d",
               name, grant, done, busy, count,
               e[EW-1 -: N], e[EW-N-1 -: N], e[W], e[W-1:0]);
    end
  endtask

  initial begin
    logic [N-1:0] oh;
    int           idx;

    // Round-robin from reset: 0,1,2,3,0 with one idle cycle between grants.
    for (int k = 0; k < 5; k++) begin
`ifdef TIMER_ARB_FIXED_PRIO_EN
      idx = 0;
`else
      idx = k % N;
`endif
      oh = N'(1) << idx;
      add(4'b1111, '0, oh, 4'b0000, 1'b1, 4'd0, "rr_count");
      add(4'b1111, '0, oh, oh,      1'b1, 4'd0, "rr_done");
      add(4'b1111, '0, '0, '0,      1'b0, 4'd0, "rr_idle");
    end
    add('0, '0, '0, '0, 1'b0, 4'd0, "rr_quiet");

    // Single requester 1, delay 3.
    add(4'b0010, dly(1, 3), 4'b0010, '0,      1'b1, 4'd3, "single_c3");
    add(4'b0010, dly(1, 3), 4'b0010, '0,      1'b1, 4'd2, "single_c2");
    add(4'b0010, dly(1, 3), 4'b0010, '0,      1'b1, 4'd1, "single_c1");
    add(4'b0010, dly(1, 3), 4'b0010, '0,      1'b1, 4'd0, "single_c0");
    add(4'b0010, dly(1, 3), 4'b0010, 4'b0010, 1'b1, 4'd0, "single_done");
    add('0,      '0,        '0,      '0,      1'b0, 4'd0, "single_idle");

    // Abort: req[2] delay 9 dropped at count 5 while req[3] waits.
    add(4'b1100, dly(2, 9) | dly(3, 2), 4'b0100, '0, 1'b1, 4'd9, "abort_load");
    for (int k = 1; k <= 4; k++)
      add(4'b1100, dly(2, 9) | dly(3, 2), 4'b0100, '0, 1'b1, W'(9 - k), "abort_count");
    add(4'b1000, dly(3, 2), '0,      '0,      1'b0, 4'd0, "abort_idle");
    add(4'b1000, dly(3, 2), 4'b1000, '0,      1'b1, 4'd2, "pend_grant");
    add(4'b1000, dly(3, 2), 4'b1000, '0,      1'b1, 4'd1, "pend_c1");
    add(4'b1000, dly(3, 2), 4'b1000, '0,      1'b1, 4'd0, "pend_c0");
    add(4'b1000, dly(3, 2), 4'b1000, 4'b1000, 1'b1, 4'd0, "pend_done");
    add('0,      '0,        '0,      '0,      1'b0, 4'd0, "pend_idle");

    // Max delay, with delay[0] scrambled during COUNT.
    add(4'b0001, dly(0, 15), 4'b0001, '0, 1'b1, 4'd15, "max_load");
    for (int k = 1; k <= 15; k++)
      add(4'b0001, dly(0, $urandom_range(0, 15)), 4'b0001, '0, 1'b1, W'(15 - k), "max_count");
    add(4'b0001, dly(0, 3), 4'b0001, 4'b0001, 1'b1, 4'd0, "max_done");
    add('0,      '0,        '0,      '0,      1'b0, 4'd0, "max_idle");

    // Delay 0.
    add(4'b0010, dly(1, 0), 4'b0010, '0,      1'b1, 4'd0, "zero_count");
    add(4'b0010, dly(1, 0), 4'b0010, 4'b0010, 1'b1, 4'd0, "zero_done");
    add('0,      '0,        '0,      '0,      1'b0, 4'd0, "zero_idle");

    // Reset values.
    rst = 1'b1; req = '0; delay = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_out('0, '0, 1'b0, 4'd0);
    check_out("reset_vals");
    total++;
    if (state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: got %0d want 0", state_dbg);
    end
    rst = 1'b0;
    tick();
    expect_out('0, '0, 1'b0, 4'd0);
    check_out("idle_after_reset");

    // Async reset in the middle of a count; moves last to 2 beforehand.
    req = 4'b0100; delay = dly(2, 9);
    expect_out(4'b0100, '0, 1'b1, 4'd9); tick(); check_out("pre_rst_load");
    expect_out(4'b0100, '0, 1'b1, 4'd8); tick(); check_out("pre_rst_c8");
    expect_out(4'b0100, '0, 1'b1, 4'd7); tick(); check_out("pre_rst_c7");
    #2 rst = 1'b1;
    #1;
    expect_out('0, '0, 1'b0, 4'd0);
    check_out("async_rst");
    tick();
    expect_out('0, '0, 1'b0, 4'd0);
    check_out("rst_held_no_done");
    rst = 1'b0; req = '0; delay = '0;
    tick();
    expect_out('0, '0, 1'b0, 4'd0);
    check_out("rst_release_idle");

    for (int i = 0; i < vecs.size(); i++) begin
      req   = vecs[i].req;
      delay = vecs[i].delay;
      expect_out(vecs[i].g, vecs[i].d, vecs[i].b, vecs[i].c);
      tick();
      check_out(vecs[i].name);
    end

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
